// File: rtl/donkey_pkg.sv
// Shared constants and types for the donkey / barrel sprite logic.
package donkey_pkg;

   localparam int BARREL_SLOTS        = 4;
   localparam int BARREL_SPAWN_PERIOD = 65_000_000;
   localparam int BARREL_THROW_CYCLES = 16_250_000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_THROW,
      ST_LAUNCH
   } SCHED_STATE_T;

   // One counter width wide enough for whichever of the two intervals is longer.
   function automatic int sched_cnt_width(input int period, input int throw_cycles);
      int longest;
      longest = (period > throw_cycles) ? period : throw_cycles;
      return (longest > 1) ? $clog2(longest) : 1;
   endfunction

endpackage

// File: rtl/rr_free_pick.sv
// Round-robin picker: first set bit of 'free' at or after 'start', wrapping upward.
module rr_free_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]                  free,
   input  logic [((N > 1) ? $clog2(N) : 1)-1:0] start,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
   output logic                          any_free
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   // Walk the wrapped order from the far end so the closest free slot wins last.
   always_comb begin
      int idx;
      ptr      = '0;
      any_free = |free;
      for (int i = N - 1; i >= 0; i--) begin
         idx = (int'(start) + i) % N;
         if (free[idx]) begin
            ptr = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/barrel_scheduler.sv
// Periodic barrel launcher: waits, raises the donkey throw flag, then pulses
// one free slot round-robin and tracks that slot until its done pulse.
module barrel_scheduler
   import donkey_pkg::*;
#(
   parameter int N_SLOTS      = BARREL_SLOTS,
   parameter int SPAWN_PERIOD = BARREL_SPAWN_PERIOD,
   parameter int THROW_CYCLES = BARREL_THROW_CYCLES
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [N_SLOTS-1:0] slot_done,
   output logic [N_SLOTS-1:0] barrel,
   output logic [N_SLOTS-1:0] active,
   output logic               throw,
   output logic [7:0]         spawn_count
);

   localparam int PW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
   localparam int CW = sched_cnt_width(SPAWN_PERIOD, THROW_CYCLES);
   localparam logic [CW-1:0] PERIOD_LAST = CW'(SPAWN_PERIOD - 1);
   localparam logic [CW-1:0] THROW_LAST  = CW'(THROW_CYCLES - 1);
   localparam logic [N_SLOTS-1:0] ONE_HOT0 = {{(N_SLOTS-1){1'b0}}, 1'b1};

   SCHED_STATE_T  state, state_nxt;
   logic [CW-1:0] period_cnt, period_nxt;
   logic [CW-1:0] throw_cnt, throw_nxt;
   logic [PW-1:0] ptr, ptr_nxt;
   logic [PW-1:0] rr_next, rr_nxt;
   logic [PW-1:0] pick_ptr;
   logic          any_free;

   rr_free_pick #(
      .N(N_SLOTS)
   ) u_pick (
      .free     (~active),
      .start    (rr_next),
      .ptr      (pick_ptr),
      .any_free (any_free)
   );

   always_comb begin
      state_nxt  = state;
      period_nxt = period_cnt;
      throw_nxt  = throw_cnt;
      ptr_nxt    = ptr;
      rr_nxt     = rr_next;
      if (!enable) begin
         state_nxt  = ST_IDLE;
         period_nxt = '0;
         throw_nxt  = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt  = ST_WAIT;
               period_nxt = '0;
            end
            ST_WAIT: begin
               // With every slot busy the counter parks at terminal until one frees.
               if (period_cnt == PERIOD_LAST) begin
                  if (any_free) begin
                     state_nxt  = ST_THROW;
                     period_nxt = '0;
                     throw_nxt  = '0;
                     ptr_nxt    = pick_ptr;
                  end
               end else begin
                  period_nxt = period_cnt + CW'(1);
               end
            end
            ST_THROW: begin
               if (throw_cnt == THROW_LAST) begin
                  state_nxt = ST_LAUNCH;
                  throw_nxt = '0;
               end else begin
                  throw_nxt = throw_cnt + CW'(1);
               end
            end
            ST_LAUNCH: begin
               state_nxt  = ST_WAIT;
               period_nxt = '0;
               rr_nxt     = (ptr == PW'(N_SLOTS - 1)) ? '0 : ptr + PW'(1);
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         period_cnt  <= '0;
         throw_cnt   <= '0;
         ptr         <= '0;
         rr_next     <= '0;
         barrel      <= '0;
         active      <= '0;
         throw       <= 1'b0;
         spawn_count <= '0;
      end else begin
         state      <= state_nxt;
         period_cnt <= period_nxt;
         throw_cnt  <= throw_nxt;
         ptr        <= ptr_nxt;
         rr_next    <= rr_nxt;
         throw      <= (state_nxt == ST_THROW);
         barrel     <= (state_nxt == ST_LAUNCH) ? (ONE_HOT0 << ptr_nxt) : '0;
         active     <= (active & ~slot_done) | barrel;
         if (state_nxt == ST_LAUNCH && spawn_count != 8'hFF) begin
            spawn_count <= spawn_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_barrel_scheduler.sv
// Scoreboard bench for barrel_scheduler with short spawn/throw intervals.
module tb_barrel_scheduler;

   localparam int N = 4;
   localparam int P = 10;
   localparam int T = 3;
   localparam int LAST_LAUNCH = 54 + 14 * 298;

   typedef struct {
      int cyc;
      int slot;
   } event_t;

   typedef struct {
      int lo;
      int hi;
   } window_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         enable = 1'b0;
   logic [N-1:0] slot_done = '0;
   logic [N-1:0] barrel;
   logic [N-1:0] active;
   logic         throw;
   logic [7:0]   spawn_count;

   event_t  launch_q[$];
   window_t throw_q[$];
   event_t  done_q[$];
   int      cyc;
   int      checks;
   int      errors;
   int      spawn_exp;

   barrel_scheduler #(
      .N_SLOTS      (N),
      .SPAWN_PERIOD (P),
      .THROW_CYCLES (T)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .slot_done   (slot_done),
      .barrel      (barrel),
      .active      (active),
      .throw       (throw),
      .spawn_count (spawn_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic en);
      enable = en;
   endtask

   task automatic expectLaunch(input int at, input int slot, input bit auto_done);
      event_t  e;
      window_t w;
      e.cyc = at;
      e.slot = slot;
      launch_q.push_back(e);
      w.lo = at - T;
      w.hi = at - 1;
      throw_q.push_back(w);
      if (auto_done) begin
         e.cyc = at + 3;
         done_q.push_back(e);
      end
   endtask

   task automatic pulseDone(input int at, input logic [N-1:0] mask);
      event_t e;
      for (int i = 0; i < N; i++) begin
         if (mask[i]) begin
            e.cyc = at;
            e.slot = i;
            done_q.push_back(e);
         end
      end
   endtask

   // Runs mid-cycle: pops due expectations, compares, and drives this cycle's done pulses.
   task automatic monitor();
      logic [N-1:0] barrel_exp;
      logic [N-1:0] done_v;
      logic         throw_exp;
      barrel_exp = '0;
      done_v = '0;
      if (launch_q.size() > 0 && launch_q[0].cyc == cyc) begin
         barrel_exp[launch_q[0].slot] = 1'b1;
         launch_q.delete(0);
         if (spawn_exp < 255) spawn_exp++;
      end
      while (throw_q.size() > 0 && throw_q[0].hi < cyc) throw_q.delete(0);
      throw_exp = (throw_q.size() > 0 && throw_q[0].lo <= cyc);
      checkOutput("barrel", 32'(barrel), 32'(barrel_exp));
      checkOutput("throw", 32'(throw), 32'(throw_exp));
      checkOutput("spawn_count", 32'(spawn_count), 32'(spawn_exp));
      for (int i = done_q.size() - 1; i >= 0; i--) begin
         if (done_q[i].cyc == cyc) begin
            done_v[done_q[i].slot] = 1'b1;
            done_q.delete(i);
         end
      end
      slot_done = done_v;
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      monitor();
   endtask

   task automatic runTo(input int target);
      while (cyc < target) step();
   endtask

   task automatic releaseReset();
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      spawn_exp = 0;
      checkOutput("reset_active", 32'(active), 32'h0);
      monitor();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      spawn_exp = 0;
      repeat (3) @(posedge clk);
      releaseReset();

      // Four launches into an empty pool, round-robin from slot 0.
      runTo(5);
      applyStimulus(1'b1);
      expectLaunch(19, 0, 1'b0);
      expectLaunch(33, 1, 1'b0);
      expectLaunch(47, 2, 1'b0);
      expectLaunch(61, 3, 1'b0);
      runTo(62);
      checkOutput("active_full", 32'(active), 32'hF);

      // Pool full: no throw until slot 2 returns.
      runTo(75);
      pulseDone(80, 4'b0100);
      expectLaunch(85, 2, 1'b0);
      runTo(81);
      checkOutput("active_slot2_freed", 32'(active), 32'hB);
      runTo(86);
      checkOutput("active_refull", 32'(active), 32'hF);

      // Next pointer is 3 but slot 3 is busy: selection wraps to slot 0.
      pulseDone(90, 4'b0111);
      expectLaunch(99, 0, 1'b0);
      runTo(91);
      checkOutput("active_only3", 32'(active), 32'h8);
      runTo(100);
      checkOutput("active_wrap", 32'(active), 32'h9);
      pulseDone(101, 4'b1000);
      expectLaunch(113, 1, 1'b0);
      runTo(114);
      checkOutput("active_pre_reset", 32'(active), 32'h3);

      // Asynchronous reset in the middle of a wait period.
      runTo(118);
      #2;
      rst_n = 1'b0;
      applyStimulus(1'b0);
      #1;
      checkOutput("async_barrel", 32'(barrel), 32'h0);
      checkOutput("async_active", 32'(active), 32'h0);
      checkOutput("async_throw", 32'(throw), 32'h0);
      checkOutput("async_spawn", 32'(spawn_count), 32'h0);
      repeat (2) @(posedge clk);
      releaseReset();

      // Same start-up as before, then abandon a throw by dropping enable.
      runTo(5);
      applyStimulus(1'b1);
      expectLaunch(19, 0, 1'b1);
      begin
         window_t w;
         w.lo = 30;
         w.hi = 31;
         throw_q.push_back(w);
      end
      runTo(31);
      applyStimulus(1'b0);
      runTo(40);
      checkOutput("active_after_abort", 32'(active), 32'h0);

      // Re-enable: full period again, then a long run with prompt returns.
      applyStimulus(1'b1);
      for (int k = 0; k < 299; k++) begin
         expectLaunch(54 + 14 * k, (1 + k) % N, 1'b1);
      end
      runTo(LAST_LAUNCH + 6);
      checkOutput("spawn_saturated", 32'(spawn_count), 32'd255);
      checkOutput("active_drained", 32'(active), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
